idma_obi_write_ot: RTL and testbench

Multi-outstanding OBI write port for the iDMA transport layer. It drains the aligned byte-lane buffer after the write barrel shifter and issues OBI write beats for one burst descriptor at a time. It keeps up to `MaxOutstanding` beats in flight and returns one error-flagged response per completed burst. It replaces the single-outstanding OBI writer, generalising outstanding depth, data width and address width.

---
 rtl/idma_obi_write_ot.sv | 209 ++++++++++++++++++++
 tb/tb_idma_obi_write_ot.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/idma_obi_write_ot.sv
// iDMA OBI write port with multiple outstanding beats: drains the aligned
// byte-lane buffer one burst descriptor at a time and returns one response per burst.
module idma_obi_write_ot #(
  parameter int unsigned DataWidth       = 32,
  parameter int unsigned AddrWidth       = 32,
  parameter int unsigned LenWidth        = 16,
  parameter int unsigned MaxOutstanding  = 4,
  parameter bit          MaskInvalidData = 1'b1,
  localparam int unsigned StrbWidth      = DataWidth / 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 meta_valid_i,
  output logic                 meta_ready_o,
  input  logic [AddrWidth-1:0] meta_addr_i,
  input  logic [LenWidth-1:0]  meta_beats_i,
  input  logic [StrbWidth-1:0] meta_first_strb_i,
  input  logic [StrbWidth-1:0] meta_last_strb_i,
  input  logic [DataWidth-1:0] buffer_out_i,
  input  logic [StrbWidth-1:0] buffer_out_valid_i,
  output logic [StrbWidth-1:0] buffer_out_ready_o,
  output logic                 obi_req_o,
  output logic                 obi_we_o,
  output logic [AddrWidth-1:0] obi_addr_o,
  output logic [StrbWidth-1:0] obi_be_o,
  output logic [DataWidth-1:0] obi_wdata_o,
  input  logic                 obi_gnt_i,
  input  logic                 obi_rvalid_i,
  input  logic                 obi_err_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic                 rsp_error_o,
  output logic                 busy_o
);

  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

  localparam logic [CntW-1:0]      MaxCnt    = CntW'(MaxOutstanding);
  localparam logic [PtrW-1:0]      LastPtr   = PtrW'(MaxOutstanding - 1);
  localparam logic [AddrWidth-1:0] AddrStep  = AddrWidth'(StrbWidth);
  localparam logic [AddrWidth-1:0] AlignMask = ~AddrWidth'(StrbWidth - 1);

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StBurst = 1'b1;

  logic [0:0]           state_q;
  logic [AddrWidth-1:0] addr_q;
  logic [LenWidth-1:0]  rem_q;
  logic                 first_q;
  logic [StrbWidth-1:0] first_strb_q;
  logic [StrbWidth-1:0] last_strb_q;

  logic [CntW-1:0]      ot_cnt_q;
  logic [CntW-1:0]      rsp_credit_q;
  logic                 err_acc_q;

  // Last-beat flags of granted beats, in grant order
  logic [MaxOutstanding-1:0] lf_mem_q;
  logic [PtrW-1:0]           lf_wr_q;
  logic [PtrW-1:0]           lf_rd_q;

  // Per-burst error flags waiting for the response handshake
  logic [MaxOutstanding-1:0] rf_mem_q;
  logic [PtrW-1:0]           rf_wr_q;
  logic [PtrW-1:0]           rf_rd_q;
  logic [CntW-1:0]           rf_cnt_q;

  logic                 in_burst;
  logic                 is_last;
  logic [StrbWidth-1:0] beat_be;
  logic                 lanes_ok;
  logic                 beat_gnt;
  logic                 last_gnt;
  logic                 meta_hs;
  logic                 burst_done;
  logic                 rsp_hs;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + PtrW'(1);
  endfunction

  assign in_burst = (state_q == StBurst);
  assign is_last  = (rem_q == '0);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    beat_be = '1;
    if (first_q && is_last) beat_be = first_strb_q & last_strb_q;
    else if (first_q)       beat_be = first_strb_q;
    else if (is_last)       beat_be = last_strb_q;
    if (!in_burst)          beat_be = '0;
  end

  assign lanes_ok  = ((buffer_out_valid_i & beat_be) == beat_be);
  assign obi_req_o = in_burst && lanes_ok && (ot_cnt_q < MaxCnt) &&
                     (!is_last || (rsp_credit_q < MaxCnt));
  assign beat_gnt  = obi_req_o && obi_gnt_i;
  assign last_gnt  = beat_gnt && is_last;

  assign buffer_out_ready_o = beat_gnt ? beat_be : '0;
  assign obi_we_o           = 1'b1;
  assign obi_addr_o         = in_burst ? addr_q : '0;
  assign obi_be_o           = beat_be;

  always_comb begin
    obi_wdata_o = '0;
    for (int i = 0; i < StrbWidth; i++) begin
      if (in_burst && (beat_be[i] || !MaskInvalidData)) obi_wdata_o[8*i +: 8] = buffer_out_i[8*i +: 8];
    end
  end

  assign meta_ready_o = (state_q == StIdle);
  assign meta_hs      = meta_valid_i && meta_ready_o;
  assign burst_done   = obi_rvalid_i && lf_mem_q[lf_rd_q];
  assign rsp_valid_o  = (rf_cnt_q != '0);
  assign rsp_error_o  = rsp_valid_o && rf_mem_q[rf_rd_q];
  assign rsp_hs       = rsp_valid_o && rsp_ready_i;
  assign busy_o       = in_burst || (ot_cnt_q != '0) || (rsp_credit_q != '0);

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      rem_q        <= '0;
      first_q      <= 1'b0;
      first_strb_q <= '0;
      last_strb_q  <= '0;
    end else if (meta_hs) begin
      state_q      <= StBurst;
      addr_q       <= meta_addr_i & AlignMask;
      rem_q        <= meta_beats_i;
      first_q      <= 1'b1;
      first_strb_q <= meta_first_strb_i;
      last_strb_q  <= meta_last_strb_i;
    end else if (beat_gnt) begin
      addr_q  <= addr_q + AddrStep;
      rem_q   <= rem_q - LenWidth'(1);
      first_q <= 1'b0;
      if (is_last) state_q <= StIdle;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ot_cnt_q     <= '0;
      rsp_credit_q <= '0;
      err_acc_q    <= 1'b0;
    end else begin
      case ({beat_gnt, obi_rvalid_i})
        2'b10:   ot_cnt_q <= ot_cnt_q + CntW'(1);
        2'b01:   ot_cnt_q <= ot_cnt_q - CntW'(1);
        default: ot_cnt_q <= ot_cnt_q;
      endcase
      case ({last_gnt, rsp_hs})
        2'b10:   rsp_credit_q <= rsp_credit_q + CntW'(1);
        2'b01:   rsp_credit_q <= rsp_credit_q - CntW'(1);
        default: rsp_credit_q <= rsp_credit_q;
      endcase
      if (obi_rvalid_i) err_acc_q <= lf_mem_q[lf_rd_q] ? 1'b0 : (err_acc_q | obi_err_i);
    end
  end

  // NOTE: the FIFO storage is only a few flops, so it is reset along with the
  // pointers; this keeps rsp_error_o and the last flags free of X after reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lf_mem_q <= '0;
      lf_wr_q  <= '0;
      lf_rd_q  <= '0;
    end else begin
      if (beat_gnt) begin
        lf_mem_q[lf_wr_q] <= is_last;
        lf_wr_q           <= ptr_inc(lf_wr_q);
      end
      if (obi_rvalid_i) lf_rd_q <= ptr_inc(lf_rd_q);
    end
  end

  // The response credit bounds rf_cnt_q, so pushes never find the FIFO full
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rf_mem_q <= '0;
      rf_wr_q  <= '0;
      rf_rd_q  <= '0;
      rf_cnt_q <= '0;
    end else begin
      if (burst_done) begin
        rf_mem_q[rf_wr_q] <= err_acc_q | obi_err_i;
        rf_wr_q           <= ptr_inc(rf_wr_q);
      end
      if (rsp_hs) rf_rd_q <= ptr_inc(rf_rd_q);
      case ({burst_done, rsp_hs})
        2'b10:   rf_cnt_q <= rf_cnt_q + CntW'(1);
        2'b01:   rf_cnt_q <= rf_cnt_q - CntW'(1);
        default: rf_cnt_q <= rf_cnt_q;
      endcase
    end
  end

  rvalid_needs_outstanding: assert property (
    @(posedge clk_i) disable iff (!rst_ni) obi_rvalid_i |-> (ot_cnt_q != '0));

  rsp_fifo_no_overflow: assert property (
    @(posedge clk_i) disable iff (!rst_ni) burst_done |-> ((rf_cnt_q < MaxCnt) || rsp_hs));

endmodule

// File: tb/tb_idma_obi_write_ot.sv
// Scoreboard bench for idma_obi_write_ot: expected beats and responses are queued
// when a descriptor is driven and compared when the DUT grants or responds.
module tb_idma_obi_write_ot;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned LW = 16;
  localparam int unsigned MO = 2;
  localparam int unsigned SW = DW / 8;

  logic          clk;
  logic          rst_n;
  logic          meta_valid_i;
  logic          meta_ready_o;
  logic [AW-1:0] meta_addr_i;
  logic [LW-1:0] meta_beats_i;
  logic [SW-1:0] meta_first_strb_i;
  logic [SW-1:0] meta_last_strb_i;
  logic [DW-1:0] buffer_out_i;
  logic [SW-1:0] buffer_out_valid_i;
  logic [SW-1:0] buffer_out_ready_o;
  logic          obi_req_o;
  logic          obi_we_o;
  logic [AW-1:0] obi_addr_o;
  logic [SW-1:0] obi_be_o;
  logic [DW-1:0] obi_wdata_o;
  logic          obi_gnt_i;
  logic          obi_rvalid_i;
  logic          obi_err_i;
  logic          rsp_valid_o;
  logic          rsp_ready_i;
  logic          rsp_error_o;
  logic          busy_o;

  idma_obi_write_ot #(
    .DataWidth      (DW),
    .AddrWidth      (AW),
    .LenWidth       (LW),
    .MaxOutstanding (MO),
    .MaskInvalidData(1'b1)
  ) dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .meta_valid_i      (meta_valid_i),
    .meta_ready_o      (meta_ready_o),
    .meta_addr_i       (meta_addr_i),
    .meta_beats_i      (meta_beats_i),
    .meta_first_strb_i (meta_first_strb_i),
    .meta_last_strb_i  (meta_last_strb_i),
    .buffer_out_i      (buffer_out_i),
    .buffer_out_valid_i(buffer_out_valid_i),
    .buffer_out_ready_o(buffer_out_ready_o),
    .obi_req_o         (obi_req_o),
    .obi_we_o          (obi_we_o),
    .obi_addr_o        (obi_addr_o),
    .obi_be_o          (obi_be_o),
    .obi_wdata_o       (obi_wdata_o),
    .obi_gnt_i         (obi_gnt_i),
    .obi_rvalid_i      (obi_rvalid_i),
    .obi_err_i         (obi_err_i),
    .rsp_valid_o       (rsp_valid_o),
    .rsp_ready_i       (rsp_ready_i),
    .rsp_error_o       (rsp_error_o),
    .busy_o            (busy_o)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [SW-1:0] be;
    logic [DW-1:0] wdata;
  } beat_t;

  typedef struct {
    int due;
    bit err;
  } pend_t;

  beat_t         beat_q[$];
  bit            rsp_q[$];
  pend_t         rv_q[$];
  int            gnt_cyc_q[$];
  int            total     = 0;
  int            bad       = 0;
  int            cyc       = 0;
  int            gnt_total = 0;
  int            rv_budget = -1;
  int            err_sel   = -1;
  logic [DW-1:0] buf_data  = 32'hDDCC_BBAA;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_data(input logic [SW-1:0] be);
    logic [DW-1:0] d;
    for (int i = 0; i < SW; i++) d[8*i +: 8] = be[i] ? buf_data[8*i +: 8] : 8'h00;
    return d;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_meta_ready"}, meta_ready_o, 1);
    check({tag, "_req"},        obi_req_o, 0);
    check({tag, "_we"},         obi_we_o, 1);
    check({tag, "_rsp_valid"},  rsp_valid_o, 0);
    check({tag, "_busy"},       busy_o, 0);
    check({tag, "_lanes"},      buffer_out_ready_o, 0);
    check({tag, "_addr"},       obi_addr_o, 0);
    check({tag, "_be"},         obi_be_o, 0);
    check({tag, "_wdata"},      obi_wdata_o, 0);
    check({tag, "_rsp_error"},  rsp_error_o, 0);
  endtask

  task automatic send_meta(input logic [AW-1:0] addr, input int beats, input logic [SW-1:0] fs,
                           input logic [SW-1:0] ls, input bit exp_err);
    logic [AW-1:0] base_a;
    logic [SW-1:0] m;
    bit            acc;
    base_a = addr & 32'hFFFF_FFFC;
    for (int b = 0; b <= beats; b++) begin
      m = 4'hF;
      if (b == 0)     m &= fs;
      if (b == beats) m &= ls;
      beat_q.push_back('{addr: base_a + AW'(4 * b), be: m, wdata: exp_data(m)});
    end
    rsp_q.push_back(exp_err);
    meta_addr_i       = addr;
    meta_beats_i      = LW'(beats);
    meta_first_strb_i = fs;
    meta_last_strb_i  = ls;
    meta_valid_i      = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = meta_ready_o;
      step();
    end
    meta_valid_i = 1'b0;
    check("meta_accept", acc, 1);
  endtask

  task automatic wait_idle(input string tag);
    bit done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (!busy_o && beat_q.size() == 0 && rsp_q.size() == 0 && rv_q.size() == 0) done = 1'b1;
    end
    check(tag, done, 1);
    step();
  endtask

  // Monitor: compares granted beats and completed responses against the queues
  initial begin : monitor
    beat_t e;
    bit    r;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (obi_req_o && obi_gnt_i) begin
          check("beat_expected", beat_q.size() != 0, 1);
          if (beat_q.size() != 0) begin
            e = beat_q.pop_front();
            check("beat_addr",  obi_addr_o, e.addr);
            check("beat_be",    obi_be_o, e.be);
            check("beat_wdata", obi_wdata_o, e.wdata);
            check("beat_lanes", buffer_out_ready_o, e.be);
          end
          rv_q.push_back('{due: cyc + 2, err: (gnt_total == err_sel)});
          gnt_cyc_q.push_back(cyc);
          gnt_total++;
        end else begin
          check("lanes_idle", buffer_out_ready_o, 0);
        end
        if (rsp_valid_o && rsp_ready_i) begin
          check("rsp_expected", rsp_q.size() != 0, 1);
          if (rsp_q.size() != 0) begin
            r = rsp_q.pop_front();
            check("rsp_error", rsp_error_o, r);
          end
        end
      end
    end
  end

  // Responder: returns rvalid two cycles after each grant, limited by rv_budget
  initial begin : responder
    obi_rvalid_i = 1'b0;
    obi_err_i    = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      cyc++;
      obi_rvalid_i = 1'b0;
      obi_err_i    = 1'b0;
      if (rst_n && rv_q.size() != 0 && rv_q[0].due <= cyc && rv_budget != 0) begin
        obi_rvalid_i = 1'b1;
        obi_err_i    = rv_q[0].err;
        void'(rv_q.pop_front());
        if (rv_budget > 0) rv_budget--;
      end
    end
  end

  initial begin : stimulus
    int base;
    rst_n              = 1'b0;
    meta_valid_i       = 1'b0;
    meta_addr_i        = '0;
    meta_beats_i       = '0;
    meta_first_strb_i  = '0;
    meta_last_strb_i   = '0;
    buffer_out_i       = buf_data;
    buffer_out_valid_i = 4'hF;
    obi_gnt_i          = 1'b0;
    rsp_ready_i        = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    step();
    rst_n = 1'b1;
    step();

    // Aligned two-beat burst, full throughput
    obi_gnt_i = 1'b1;
    rv_budget = -1;
    base = gnt_cyc_q.size();
    send_meta(32'h0000_0100, 1, 4'hF, 4'hF, 1'b0);
    wait_idle("t1_idle");
    check("t1_back_to_back", gnt_cyc_q[base + 1] - gnt_cyc_q[base], 1);

    // Masked single beat; low address bits ignored
    send_meta(32'h0000_0202, 0, 4'hE, 4'h3, 1'b0);
    wait_idle("t2_idle");

    // Outstanding limit with rvalid withheld, then grant and rvalid together
    obi_gnt_i = 1'b0;
    rv_budget = 0;
    base = gnt_total;
    send_meta(32'h0000_0300, 3, 4'hF, 4'hF, 1'b0);
    obi_gnt_i = 1'b1;
    repeat (6) step();
    @(negedge clk);
    check("t3_grants", gnt_total - base, 2);
    check("t3_stall", obi_req_o, 0);
    step();
    obi_gnt_i = 1'b0;
    rv_budget = 1;
    @(negedge clk);
    check("t3_still_full", obi_req_o, 0);
    step();
    @(negedge clk);
    check("t3_release_req", obi_req_o, 1);
    step();
    obi_gnt_i = 1'b1;
    rv_budget = 1;
    @(negedge clk);
    check("t3_gnt_with_rvalid", obi_rvalid_i && obi_req_o, 1);
    step();
    @(negedge clk);
    check("t3_after_same_cycle_req", obi_req_o, 1);
    step();
    rv_budget = -1;
    wait_idle("t3_idle");
    check("t3_grants_all", gnt_total - base, 4);

    // Error on the second beat only, then a clean burst
    err_sel = gnt_total + 1;
    send_meta(32'h0000_0400, 2, 4'hF, 4'hF, 1'b1);
    wait_idle("t4_idle_err");
    err_sel = -1;
    send_meta(32'h0000_0500, 0, 4'hF, 4'hF, 1'b0);
    wait_idle("t4_idle_clean");

    // Response credit: the third single-beat burst waits for a response handshake
    rsp_ready_i = 1'b0;
    base = gnt_total;
    send_meta(32'h0000_0600, 0, 4'hF, 4'hF, 1'b0);
    send_meta(32'h0000_0610, 0, 4'hF, 4'hF, 1'b0);
    send_meta(32'h0000_0620, 0, 4'hF, 4'hF, 1'b0);
    repeat (5) step();
    @(negedge clk);
    check("t5_grants", gnt_total - base, 2);
    check("t5_stall", obi_req_o, 0);
    check("t5_rsp_hold", rsp_valid_o, 1);
    check("t5_busy", busy_o, 1);
    step();
    rsp_ready_i = 1'b1;
    wait_idle("t5_idle");
    check("t5_grants_all", gnt_total - base, 3);

    // Reset in the middle of a burst drops everything in flight
    obi_gnt_i = 1'b0;
    rv_budget = 0;
    send_meta(32'h0000_0700, 5, 4'hF, 4'hF, 1'b0);
    obi_gnt_i = 1'b1;
    step();
    step();
    @(negedge clk);
    check("t6_busy_before_reset", busy_o, 1);
    step();
    rst_n = 1'b0;
    beat_q.delete();
    rsp_q.delete();
    rv_q.delete();
    @(negedge clk);
    check_reset_outputs("midreset");
    step();
    rst_n     = 1'b1;
    rv_budget = -1;
    step();
    @(negedge clk);
    check("t6_idle_after_reset", busy_o, 0);
    step();

    // Address wrap at the top of the address space
    send_meta(32'hFFFF_FFFC, 1, 4'hF, 4'hF, 1'b0);
    wait_idle("t6_wrap_idle");

    check("end_beat_q", beat_q.size(), 0);
    check("end_rsp_q", rsp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
